// File: rtl/hrm_mm_sched.sv
// hrm_mm_sched
//   Per-cycle packet scheduler for the hot-redundancy memory manager.
//   Each accepted cyc_start latches the slot enable mask and flips the
//   ping-pong channel. The block then walks slots 0..PKT_NUM-1 in order and
//   issues one pkt_req per enabled slot. For each request it waits for
//   pkt_ack, or gives up after TOUT_CYC cycles and counts a timeout.
//
// Ports
//   clk_100m, rst_100m     clock, asynchronous active-high reset
//   cyc_start              start pulse (ignored with overrun while busy)
//   pkt_en_mask[15:0]      slot enables, sampled on accepted cyc_start
//   pkt_ack                transfer-finished pulse, only honoured in WAIT
//   pkt_req, pkt_num[3:0]  request pulse and slot index
//   chn_sel                ping-pong select, toggles per accepted cycle
//   busy                   scheduler not idle
//   cyc_done               all slots handled
//   tout_err               current packet timed out
//   overrun                cyc_start arrived while busy
//   err_cnt[ERR_W-1:0]     saturating timeout count, cleared only by reset
module hrm_mm_sched #(
   parameter int unsigned PKT_NUM  = 8,
   parameter int unsigned TOUT_CYC = 2000,
   parameter int unsigned ERR_W    = 8
) (
   input  logic             clk_100m,
   input  logic             rst_100m,
   input  logic             cyc_start,
   input  logic [15:0]      pkt_en_mask,
   input  logic             pkt_ack,
   output logic             pkt_req,
   output logic [3:0]       pkt_num,
   output logic             chn_sel,
   output logic             busy,
   output logic             cyc_done,
   output logic             tout_err,
   output logic             overrun,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned    TW      = $clog2(TOUT_CYC);
   localparam logic [TW-1:0]  T_LAST  = TW'(TOUT_CYC - 1);
   localparam logic [4:0]     IDX_END = 5'(PKT_NUM);

   typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, DONE} state_t;

   state_t           state_q, state_d;
   logic [4:0]       idx_q, idx_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [15:0]      mask_q, mask_d;
   logic             chn_sel_q, chn_sel_d;
   logic [3:0]       pkt_num_q, pkt_num_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic             pkt_req_q, pkt_req_d;
   logic             busy_q, busy_d;
   logic             cyc_done_q, cyc_done_d;
   logic             tout_err_q, tout_err_d;
   logic             overrun_q, overrun_d;

   always_ff @(posedge clk_100m or posedge rst_100m) begin
      if (rst_100m) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         timer_q    <= '0;
         mask_q     <= '0;
         chn_sel_q  <= 1'b0;
         pkt_num_q  <= '0;
         err_cnt_q  <= '0;
         pkt_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         cyc_done_q <= 1'b0;
         tout_err_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         timer_q    <= timer_d;
         mask_q     <= mask_d;
         chn_sel_q  <= chn_sel_d;
         pkt_num_q  <= pkt_num_d;
         err_cnt_q  <= err_cnt_d;
         pkt_req_q  <= pkt_req_d;
         busy_q     <= busy_d;
         cyc_done_q <= cyc_done_d;
         tout_err_q <= tout_err_d;
         overrun_q  <= overrun_d;
      end
   end

   // pkt_req and cyc_done are registered from the REQ/DONE state itself, so
   // they appear one cycle after entering that state; tout_err, overrun and
   // busy follow the decision taken on the same edge.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      timer_d    = timer_q;
      mask_d     = mask_q;
      chn_sel_d  = chn_sel_q;
      pkt_num_d  = pkt_num_q;
      err_cnt_d  = err_cnt_q;
      pkt_req_d  = 1'b0;
      cyc_done_d = 1'b0;
      tout_err_d = 1'b0;
      overrun_d  = cyc_start && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (cyc_start) begin
               mask_d    = pkt_en_mask;
               idx_d     = '0;
               chn_sel_d = ~chn_sel_q;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (idx_q == IDX_END) begin
               state_d = DONE;
            end else if (mask_q[idx_q[3:0]]) begin
               state_d = REQ;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         REQ: begin
            pkt_req_d = 1'b1;
            pkt_num_d = idx_q[3:0];
            timer_d   = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            // ack has priority over a timeout landing on the same cycle
            if (pkt_ack) begin
               idx_d   = idx_q + 5'd1;
               state_d = SCAN;
            end else if (timer_q == T_LAST) begin
               tout_err_d = 1'b1;
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + ERR_W'(1);
               end
               idx_d   = idx_q + 5'd1;
               state_d = SCAN;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DONE: begin
            cyc_done_d = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign pkt_req  = pkt_req_q;
   assign pkt_num  = pkt_num_q;
   assign chn_sel  = chn_sel_q;
   assign busy     = busy_q;
   assign cyc_done = cyc_done_q;
   assign tout_err = tout_err_q;
   assign overrun  = overrun_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_hrm_mm_sched.sv
// tb_hrm_mm_sched
//   Randomized bench for hrm_mm_sched. For every scheduling cycle a timeline
//   is planned from the slot rules (edge offsets of each request, ack,
//   timeout and completion), the planned stimulus is driven, and all outputs
//   are compared against that timeline after every clock edge.
module tb_hrm_mm_sched;

   localparam int unsigned PN   = 8;
   localparam int unsigned TO   = 40;
   localparam int unsigned EW   = 8;
   localparam int          LMAX = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          cyc_start;
   logic [15:0]   mask_in;
   logic          pkt_ack;
   logic          pkt_req;
   logic [3:0]    pkt_num;
   logic          chn_sel;
   logic          busy;
   logic          cyc_done;
   logic          tout_err;
   logic          overrun;
   logic [EW-1:0] err_cnt;

   hrm_mm_sched #(
      .PKT_NUM  (PN),
      .TOUT_CYC (TO),
      .ERR_W    (EW)
   ) dut (
      .clk_100m    (clk),
      .rst_100m    (rst),
      .cyc_start   (cyc_start),
      .pkt_en_mask (mask_in),
      .pkt_ack     (pkt_ack),
      .pkt_req     (pkt_req),
      .pkt_num     (pkt_num),
      .chn_sel     (chn_sel),
      .busy        (busy),
      .cyc_done    (cyc_done),
      .tout_err    (tout_err),
      .overrun     (overrun),
      .err_cnt     (err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference state carried across cycles
   int m_err = 0;
   int m_chn = 0;

   // planned timeline, indexed by edge offset from the accepted cyc_start
   bit e_req [LMAX];
   int e_num [LMAX];
   bit e_tout[LMAX];
   bit e_done[LMAX];
   bit e_ovr [LMAX];
   bit ack_at[LMAX];
   bit st_at [LMAX];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_req"},  pkt_req, 0);
      check({tag, "_done"}, cyc_done, 0);
      check({tag, "_tout"}, tout_err, 0);
      check({tag, "_ovr"},  overrun, 0);
      check({tag, "_chn"},  chn_sel, m_chn);
      check({tag, "_err"},  err_cnt, m_err);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_start = 1'b0;
         pkt_ack   = 1'($urandom_range(0, 1));
         mask_in   = 16'($urandom);
         @(posedge clk);
         #1;
         check_quiet("idle");
      end
      pkt_ack = 1'b0;
   endtask

   // mode: 0 random ack/timeout, 1 ack 3 cycles after req, 2 never ack,
   //       3 ack on the exact timeout cycle
   task automatic run_sched(input logic [15:0] mask, input int mode,
                            input bit do_ovr, input bit do_rst);
      int cur;
      int last;
      int r;
      int d;
      int rst_t;
      int sel;
      for (int t = 0; t < LMAX; t++) begin
         e_req[t] = 0; e_num[t] = 0; e_tout[t] = 0; e_done[t] = 0;
         e_ovr[t] = 0; ack_at[t] = 0; st_at[t] = 0;
      end
      rst_t = -1;
      cur   = 1;                          // edge at which slot 0 is examined
      for (int i = 0; i < int'(PN); i++) begin
         if (mask[i]) begin
            r        = cur + 1;           // pkt_req visible after this edge
            e_req[r] = 1;
            e_num[r] = i;
            case (mode)
               1:       d = 3;
               2:       d = 0;
               3:       d = TO;
               default: begin
                  sel = $urandom_range(0, 9);
                  if (sel < 2)       d = 0;
                  else if (sel == 2) d = TO;
                  else               d = $urandom_range(1, 8);
               end
            endcase
            if (d > 0) begin
               ack_at[r + d] = 1;
               cur = r + d + 1;
            end else begin
               e_tout[r + TO] = 1;
               cur = r + TO + 1;
            end
            if (do_rst && rst_t < 0) rst_t = r;
         end else begin
            if ($urandom_range(0, 3) == 0) ack_at[cur] = 1;   // stray ack in SCAN
            cur = cur + 1;
         end
      end
      last = cur + 1;
      e_done[last] = 1;
      if (do_ovr) begin
         sel = $urandom_range(1, last);
         st_at[sel] = 1;
         e_ovr[sel] = 1;
      end
      m_chn = 1 - m_chn;

      for (int t = 0; t <= last; t++) begin
         cyc_start = (t == 0) || st_at[t];
         pkt_ack   = ack_at[t];
         mask_in   = (t == 0) ? mask : 16'($urandom);
         @(posedge clk);
         #1;
         if (e_tout[t] && m_err < 255) m_err++;
         check("busy",     busy,     t <= cur);
         check("pkt_req",  pkt_req,  e_req[t]);
         if (e_req[t]) check("pkt_num", pkt_num, e_num[t]);
         check("tout_err", tout_err, e_tout[t]);
         check("cyc_done", cyc_done, e_done[t]);
         check("overrun",  overrun,  e_ovr[t]);
         check("chn_sel",  chn_sel,  m_chn);
         check("err_cnt",  err_cnt,  m_err);
         if (t == rst_t) begin
            rst = 1'b1;
            #2;
            m_chn = 0;
            m_err = 0;
            check("rst_busy", busy,     0);
            check("rst_req",  pkt_req,  0);
            check("rst_num",  pkt_num,  0);
            check("rst_chn",  chn_sel,  0);
            check("rst_done", cyc_done, 0);
            check("rst_tout", tout_err, 0);
            check("rst_ovr",  overrun,  0);
            check("rst_err",  err_cnt,  0);
            cyc_start = 1'b0;
            pkt_ack   = 1'b0;
            #2;
            rst = 1'b0;
            return;
         end
      end
      cyc_start = 1'b0;
      pkt_ack   = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      cyc_start = 1'b0;
      pkt_ack   = 1'b0;
      mask_in   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_num", pkt_num, 0);
      check_quiet("reset");
      #3;
      rst = 1'b0;
      idle(2);

      run_sched(16'h0005, 1, 0, 0);     // slots 0 and 2, ack after 3
      idle(2);
      run_sched(16'h0000, 0, 0, 0);     // empty mask
      idle(1);
      run_sched(16'h0002, 2, 0, 0);     // timeout on slot 1
      run_sched(16'h0001, 3, 0, 0);     // ack on the timeout cycle
      run_sched(16'h00A5, 0, 1, 0);     // overrun while busy
      idle(1);
      run_sched(16'hFF3C, 0, 0, 1);     // reset while waiting
      idle(2);
      run_sched(16'h0001, 1, 0, 0);     // restart from slot 0
      run_sched(16'hFF00, 0, 1, 0);     // only out-of-range bits set

      for (int n = 0; n < 20; n++) begin
         run_sched(16'($urandom), 0, 1'($urandom_range(0, 1)), 0);
         idle($urandom_range(0, 2));
      end

      for (int n = 0; n < 38; n++) begin
         run_sched(16'h00FF, 2, 0, 0);
      end
      check("err_sat", err_cnt, 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
